multi_debouncer: RTL and testbench

Parametrised N-channel switch/button debouncer. It replaces single-channel debouncer instances on the board-input path, between raw pushbutton/switch pins and the control logic (pipeline step/run controls, VGA mode selects). Each channel has a configurable tick-counted stability window and a selectable eager or glitch-rejecting mode. Each channel outputs a clean level plus one-cycle press and release pulses.

---
 rtl/multi_debouncer_pkg.sv | 26 ++
 rtl/multi_debouncer_if.sv | 36 +++
 rtl/multi_debouncer_chan.sv | 114 +++++++++++
 rtl/multi_debouncer.sv | 74 +++++++
 tb/tb_multi_debouncer.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_debouncer_pkg.sv
// Shared debouncer definitions: per-channel state encoding and a sizing helper.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
// Contents:
//   chan_state_e  - 2-bit channel FSM encoding (OFF, WAIT_ON, ON, WAIT_OFF)
//   min_count_w() - smallest counter width that can hold a given THRESH
package debounce_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'b00,
        WAIT_ON  = 2'b01,
        ON       = 2'b10,
        WAIT_OFF = 2'b11
    } chan_state_e;

    // Smallest width w such that THRESH fits in w bits (2**w - 1 >= thresh).
    function automatic int min_count_w(input int thresh);
        int w;
        w = 1;
        while (((1 << w) - 1) < thresh) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Bundle of the debouncer's sample tick, raw inputs and cleaned outputs.
// Latency: n/a (wires only).
// Backpressure: none; outputs are levels and single-cycle pulses.
// Signals:
//   en    - sample tick, counters advance only when high
//   in    - N raw switch pins
//   level - N debounced pressed levels (1 = pressed)
//   rise  - N one-cycle pulses on level 0->1
//   fall  - N one-cycle pulses on level 1->0
// Modports: master = input source / consumer, slave = debouncer.
interface multi_debouncer_if #(
    parameter int N = 4
);
    logic         en;
    logic [N-1:0] in;
    logic [N-1:0] level;
    logic [N-1:0] rise;
    logic [N-1:0] fall;

    modport master (
        output en,
        output in,
        input  level,
        input  rise,
        input  fall
    );

    modport slave (
        input  en,
        input  in,
        output level,
        output rise,
        output fall
    );

endinterface

// File: rtl/multi_debouncer_chan.sv
// One debouncer channel: 4-state FSM, en-tick counter, registered edge pulses.
// Latency: level after THRESH en ticks (glitch-rejecting) or next edge (eager).
// Backpressure: none; the channel always accepts a new sample every cycle.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   en           - sample tick
//   p            - normalised pressed indication (1 = pressed)
//   level        - debounced level, decoded from the state register
//   rise, fall   - one-cycle pulses aligned with the level change
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int COUNT_W = 3,
    parameter int THRESH  = 4,
    parameter int EAGER   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic p,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam bit                 IS_EAGER = (EAGER != 0);
    localparam logic [COUNT_W-1:0] LAST     = COUNT_W'(THRESH - 1);

    chan_state_e        state_q, state_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               rise_q, fall_q;
    logic               level_now, level_next;

    // Eager mode shows the new level as soon as the wait window opens;
    // glitch-rejecting mode holds the old level until the window closes.
    function automatic logic level_of(input chan_state_e s);
        if (IS_EAGER) begin
            return (s == WAIT_ON) || (s == ON);
        end
        return (s == ON) || (s == WAIT_OFF);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            OFF: begin
                if (p) begin
                    state_d = WAIT_ON;
                    cnt_d   = '0;
                end
            end
            ON: begin
                if (!p) begin
                    state_d = WAIT_OFF;
                    cnt_d   = '0;
                end
            end
            WAIT_ON: begin
                // Reversion wins over a completing tick in the same cycle.
                if (!IS_EAGER && !p) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == LAST) begin
                        state_d = ON;
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
            end
            WAIT_OFF: begin
                if (!IS_EAGER && p) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == LAST) begin
                        state_d = OFF;
                    end else begin
                        cnt_d = cnt_q + COUNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    assign level_now  = level_of(state_q);
    assign level_next = level_of(state_d);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Pulses land in the same cycle the new level becomes visible.
            // An eager window completing keeps the level, so it pulses nothing.
            rise_q  <= level_next & ~level_now;
            fall_q  <= ~level_next & level_now;
        end
    end

    assign level = level_now;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel switch debouncer with per-channel level, rise and fall outputs.
// Latency: THRESH en ticks + 1 edge (eager: 1 edge); +2 with the input synchroniser.
// Backpressure: none; every channel is serviced every cycle.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   bus        - multi_debouncer_if.slave (en, in -> level, rise, fall)
// Build option: define MULTI_DEBOUNCER_SYNC_EN to put a 2-flop synchroniser
// on every raw input; leave it undefined when inputs are already synchronous.
module multi_debouncer
    import debounce_pkg::*;
#(
    parameter int N          = 4,
    parameter int COUNT_W    = 3,
    parameter int THRESH     = 4,
    parameter int EAGER      = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic               clk,
    input  logic               reset,
    multi_debouncer_if.slave   bus
);

    logic [N-1:0] raw;
    logic [N-1:0] p;
    logic [N-1:0] level_w;
    logic [N-1:0] rise_w;
    logic [N-1:0] fall_w;

`ifdef MULTI_DEBOUNCER_SYNC_EN
    // Synchroniser resets to the released pin level so no phantom press
    // is seen while it fills after reset.
    localparam logic [N-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
        end else begin
            sync1_q <= bus.in;
            sync2_q <= sync1_q;
        end
    end

    assign raw = sync2_q;
`else
    assign raw = bus.in;
`endif

    assign p = (ACTIVE_LOW != 0) ? ~raw : raw;

    for (genvar g = 0; g < N; g++) begin : g_chan
        debounce_chan #(
            .COUNT_W (COUNT_W),
            .THRESH  (THRESH),
            .EAGER   (EAGER)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .en    (bus.en),
            .p     (p[g]),
            .level (level_w[g]),
            .rise  (rise_w[g]),
            .fall  (fall_w[g])
        );
    end

    assign bus.level = level_w;
    assign bus.rise  = rise_w;
    assign bus.fall  = fall_w;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: a glitch-rejecting and an eager instance share stimulus.
// Reference model tracks "pending change / lockout + en ticks seen" per channel.
// Directed scenarios first, then a randomised bounce phase.
module tb_multi_debouncer;

    localparam int N      = 4;
    localparam int THRESH = 4;
`ifdef MULTI_DEBOUNCER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multi_debouncer_if #(.N(N)) bus0 ();
    multi_debouncer_if #(.N(N)) bus1 ();

    multi_debouncer #(
        .N(N), .COUNT_W(3), .THRESH(THRESH), .EAGER(0), .ACTIVE_LOW(1)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    multi_debouncer #(
        .N(N), .COUNT_W(3), .THRESH(THRESH), .EAGER(1), .ACTIVE_LOW(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: index 0 = glitch-rejecting, index 1 = eager.
    logic [N-1:0] m_lvl  [2];
    logic [N-1:0] m_rise [2];
    logic [N-1:0] m_fall [2];
    logic [N-1:0] m_busy [2];
    int           m_tk   [2][N];
    logic [N-1:0] m_s1, m_s2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_lvl[d]  = '0;
            m_rise[d] = '0;
            m_fall[d] = '0;
            m_busy[d] = '0;
            for (int i = 0; i < N; i++) m_tk[d][i] = 0;
        end
        m_s1 = '1;
        m_s2 = '1;
    endtask

    // Apply one clock edge to the model using the pin values seen at that edge.
    task automatic model_edge(input logic [N-1:0] a, input logic e);
        logic [N-1:0] raw, p, old;
        if (SYNC_LAT != 0) begin
            raw  = m_s2;
            m_s2 = m_s1;
            m_s1 = a;
        end else begin
            raw = a;
        end
        p = ~raw;
        for (int d = 0; d < 2; d++) begin
            old = m_lvl[d];
            for (int i = 0; i < N; i++) begin
                if (d == 0) begin
                    // Level changes only after THRESH ticks of an uninterrupted difference.
                    if (p[i] == m_lvl[0][i]) begin
                        m_busy[0][i] = 1'b0;
                    end else if (!m_busy[0][i]) begin
                        m_busy[0][i] = 1'b1;
                        m_tk[0][i]   = 0;
                    end else if (e) begin
                        m_tk[0][i]++;
                        if (m_tk[0][i] == THRESH) begin
                            m_lvl[0][i]  = p[i];
                            m_busy[0][i] = 1'b0;
                        end
                    end
                end else begin
                    // Level follows immediately, then input is ignored for THRESH ticks.
                    if (m_busy[1][i]) begin
                        if (e) begin
                            m_tk[1][i]++;
                            if (m_tk[1][i] == THRESH) m_busy[1][i] = 1'b0;
                        end
                    end else if (p[i] != m_lvl[1][i]) begin
                        m_lvl[1][i]  = p[i];
                        m_busy[1][i] = 1'b1;
                        m_tk[1][i]   = 0;
                    end
                end
            end
            m_rise[d] = m_lvl[d] & ~old;
            m_fall[d] = ~m_lvl[d] & old;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".lvl0"},  32'(bus0.level), 32'(m_lvl[0]));
        chk({tag, ".rise0"}, 32'(bus0.rise),  32'(m_rise[0]));
        chk({tag, ".fall0"}, 32'(bus0.fall),  32'(m_fall[0]));
        chk({tag, ".lvl1"},  32'(bus1.level), 32'(m_lvl[1]));
        chk({tag, ".rise1"}, 32'(bus1.rise),  32'(m_rise[1]));
        chk({tag, ".fall1"}, 32'(bus1.fall),  32'(m_fall[1]));
    endtask

    task automatic drive(input logic [N-1:0] a, input logic e);
        bus0.in = a;
        bus1.in = a;
        bus0.en = e;
        bus1.en = e;
    endtask

    task automatic step(input logic [N-1:0] a, input logic e, input string tag);
        drive(a, e);
        @(posedge clk);
        model_edge(a, e);
        #1;
        check_all(tag);
    endtask

    // Edges (0 = first edge seeing the new pins) until level[ch] changes.
    task automatic measure(input int ch, input logic [N-1:0] a, input string tag,
                           output int lat0, output int lat1);
        logic s0, s1;
        s0   = bus0.level[ch];
        s1   = bus1.level[ch];
        lat0 = -1;
        lat1 = -1;
        for (int e = 0; e < 20; e++) begin
            step(a, 1'b1, tag);
            if (lat0 < 0 && bus0.level[ch] != s0) lat0 = e;
            if (lat1 < 0 && bus1.level[ch] != s1) lat1 = e;
        end
    endtask

    initial begin
        int          l0, l1;
        int          seen, nrise, nfall;
        logic [N-1:0] a;

        // Reset with every pin pressed: outputs must stay clear.
        reset = 1'b1;
        drive(4'h0, 1'b1);
        #1 reset = 1'b0;
        model_reset();
        #2 check_all("reset_async");
        repeat (3) @(posedge clk);
        #1 check_all("reset_hold");
        drive(4'hF, 1'b1);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) step(4'hF, 1'b1, "idle");

        // Clean press and release on channel 0.
        measure(0, 4'hE, "press0", l0, l1);
        chk("press0_lat_glitchrej", 32'(l0), 32'(4 + SYNC_LAT));
        chk("press0_lat_eager",     32'(l1), 32'(SYNC_LAT));
        measure(0, 4'hF, "rel0", l0, l1);
        chk("rel0_lat_glitchrej", 32'(l0), 32'(4 + SYNC_LAT));
        chk("rel0_lat_eager",     32'(l1), 32'(SYNC_LAT));

        // Repeated 3-cycle bounce on channel 1 never makes it through.
        seen = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 3; c++) begin
                step(4'hD, 1'b1, "bounce1");
                if (bus0.level[1] || bus0.rise[1]) seen++;
            end
            step(4'hF, 1'b1, "bounce1");
            if (bus0.level[1] || bus0.rise[1]) seen++;
        end
        chk("bounce1_never_asserts", 32'(seen), 32'd0);
        for (int c = 0; c < 12; c++) step(4'hF, 1'b1, "settle");

        // Throttled tick: en high on every 4th cycle, channel 2 held pressed.
        l0 = -1;
        for (int c = 0; c < 40; c++) begin
            step(4'hB, (c % 4) == 3, "throttle2");
            if (l0 < 0 && bus0.level[2]) l0 = c;
        end
        chk("throttle2_lat", 32'(l0), 32'd15);
        for (int c = 0; c < 12; c++) step(4'hF, 1'b1, "settle");

        // Eager lockout: channel 3 chatters 0,1,0,1 then stays pressed.
        nrise = 0;
        nfall = 0;
        l1    = -1;
        for (int c = 0; c < 16; c++) begin
            case (c)
                1, 3:    a = 4'hF;
                default: a = 4'h7;
            endcase
            step(a, 1'b1, "eager3");
            if (bus1.rise[3]) nrise++;
            if (bus1.fall[3]) nfall++;
            if (l1 < 0 && bus1.level[3]) l1 = c;
        end
        chk("eager3_lat",   32'(l1),    32'(SYNC_LAT));
        chk("eager3_rises", 32'(nrise), 32'd1);
        chk("eager3_falls", 32'(nfall), 32'd0);
        for (int c = 0; c < 12; c++) step(4'hF, 1'b1, "settle");

        // Reset in the middle of a press window, pin kept pressed across it.
        for (int c = 0; c < 2 + SYNC_LAT; c++) step(4'hE, 1'b1, "midwin");
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("midwin_reset");
        @(posedge clk);
        #2 reset = 1'b1;
        measure(0, 4'hE, "restart0", l0, l1);
        chk("restart0_lat_glitchrej", 32'(l0), 32'(4 + SYNC_LAT));
        chk("restart0_lat_eager",     32'(l1), 32'(SYNC_LAT));
        for (int c = 0; c < 12; c++) step(4'hF, 1'b1, "settle");

        // Random bouncing on all channels with a random tick.
        a = 4'hF;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) a[i] = ~a[i];
            end
            step(a, 1'($urandom_range(0, 1)), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
